// File: rtl/frame_byte_serializer_pkg.sv
// Shared definitions for the frame byte serializer: default geometry, FSM encoding
// and the index-width helper.
package frame_byte_serializer_pkg;

    localparam int unsigned DefWidth  = 8;
    localparam int unsigned DefNbytes = 5;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } state_e;

    // A single-byte frame still needs a 1-bit index register.
    function automatic int unsigned idx_width(input int unsigned nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/frame_byte_serializer_if.sv
// Load/output handshake bundle for the frame byte serializer. The serializer sits on
// the slave side; the frame source and byte consumer sit on the master side.
interface frame_byte_serializer_if
    import frame_byte_serializer_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned NBYTES = DefNbytes
) ();

    logic                      load_valid;
    logic [WIDTH*NBYTES-1:0]   frame;
    logic                      load_ready;
    logic                      flush;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_byte;
    logic                      out_ready;
    logic                      out_last;
    logic                      busy;

    modport master (
        output load_valid,
        output frame,
        output flush,
        output out_ready,
        input  load_ready,
        input  out_valid,
        input  out_byte,
        input  out_last,
        input  busy
    );

    modport slave (
        input  load_valid,
        input  frame,
        input  flush,
        input  out_ready,
        output load_ready,
        output out_valid,
        output out_byte,
        output out_last,
        output busy
    );

endinterface

// File: rtl/frame_byte_index_counter.sv
// Byte index for the serializer: clears to 0, advances on each accepted byte and
// wraps after the final byte so it never exceeds NBYTES-1.
module frame_byte_index_counter
    import frame_byte_serializer_pkg::*;
#(
    parameter  int unsigned NBYTES = DefNbytes,
    localparam int unsigned IdxW   = idx_width(NBYTES)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            advance_i,
    output logic [IdxW-1:0] idx_o,
    output logic            last_o
);

    logic [IdxW-1:0] idx_q, idx_d;
    logic            at_last;

    assign at_last = (idx_q == IdxW'(NBYTES - 1));

    always_comb begin
        idx_d = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (advance_i) begin
            idx_d = at_last ? '0 : idx_q + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = at_last;

endmodule

// File: rtl/frame_byte_serializer.sv
// Captures a parallel frame and presents it one byte per accepted handshake,
// byte 0 first, with out_last on the final byte.
module frame_byte_serializer
    import frame_byte_serializer_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned NBYTES = DefNbytes
) (
    input logic                     clock,
    input logic                     reset,
    frame_byte_serializer_if.slave  bus_io
);

    localparam int unsigned IdxW = idx_width(NBYTES);

    state_e                    state_q, state_d;
    logic [WIDTH*NBYTES-1:0]   frame_q, frame_d;
    logic [WIDTH-1:0]          frame_bytes [NBYTES];
    logic [IdxW-1:0]           idx;
    logic                      idx_last;
    logic                      sending;
    logic                      load_hs;
    logic                      out_hs;

    assign sending = (state_q == StSend);
    assign load_hs = (state_q == StIdle) && bus_io.load_valid;
    assign out_hs  = sending && bus_io.out_ready;

    // Flush overrides both the load handshake and the end-of-frame transition.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        if (bus_io.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.load_valid) begin
                        frame_d = bus_io.frame;
                        state_d = StSend;
                    end
                end
                StSend: begin
                    if (out_hs && idx_last) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
        end
    end

    frame_byte_index_counter #(
        .NBYTES (NBYTES)
    ) u_index (
        .clk_i     (clock),
        .rst_i     (reset),
        .clear_i   (bus_io.flush || load_hs),
        .advance_i (out_hs),
        .idx_o     (idx),
        .last_o    (idx_last)
    );

    // The frame register is never shifted; the index picks the byte out of it.
    always_comb begin
        for (int k = 0; k < NBYTES; k++) begin
            frame_bytes[k] = frame_q[k*WIDTH +: WIDTH];
        end
    end

    assign bus_io.load_ready = !sending;
    assign bus_io.busy       = sending;
    assign bus_io.out_valid  = sending;
    assign bus_io.out_last   = sending && idx_last;
    assign bus_io.out_byte   = sending ? frame_bytes[idx] : '0;

endmodule

// File: tb/tb_frame_byte_serializer.sv
// Directed bench for frame_byte_serializer: expected bytes are queued when a frame
// is loaded and popped as the consumer accepts them.
module tb_frame_byte_serializer;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned NBYTES = 5;

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    frame_byte_serializer_if #(.WIDTH(WIDTH), .NBYTES(NBYTES)) bus ();

    frame_byte_serializer #(
        .WIDTH  (WIDTH),
        .NBYTES (NBYTES)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus_io (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".load_ready"}, 64'(bus.load_ready), 64'd1);
        check({tag, ".out_valid"},  64'(bus.out_valid),  64'd0);
        check({tag, ".out_last"},   64'(bus.out_last),   64'd0);
        check({tag, ".busy"},       64'(bus.busy),       64'd0);
        check({tag, ".out_byte"},   64'(bus.out_byte),   64'd0);
    endtask

    // Offer a frame in IDLE for one cycle and queue its bytes in send order.
    task automatic load_frame(input logic [WIDTH*NBYTES-1:0] f);
        check("load.load_ready", 64'(bus.load_ready), 64'd1);
        bus.load_valid = 1'b1;
        bus.frame      = f;
        step();
        bus.load_valid = 1'b0;
        for (int k = 0; k < NBYTES; k++) begin
            sb.push_back('{last: (k == NBYTES - 1), data: f[k*WIDTH +: WIDTH]});
        end
    endtask

    // pattern 0: out_ready always 1; pattern 1: out_ready 1,0,0,1,0,0,...
    task automatic send(input int pattern, input int nbytes, input bit stuff_load);
        int done;
        int cyc;
        exp_t e;
        done = 0;
        cyc  = 0;
        while (done < nbytes && cyc < 4 * nbytes + 8) begin
            bus.out_ready = (pattern == 0) ? 1'b1 : (cyc % 3 == 0);
            if (stuff_load) begin
                bus.load_valid = 1'b1;
                bus.frame      = 40'hAAAAAAAAAA;
            end
            #1;
            e = (sb.size() > 0) ? sb[0] : '0;
            check("send.out_valid",  64'(bus.out_valid),  64'd1);
            check("send.load_ready", 64'(bus.load_ready), 64'd0);
            check("send.out_byte",   64'(bus.out_byte),   64'(e.data));
            check("send.out_last",   64'(bus.out_last),   64'(e.last));
            if (bus.out_ready && sb.size() > 0) begin
                void'(sb.pop_front());
                done++;
            end
            step();
            cyc++;
        end
        bus.out_ready  = 1'b0;
        bus.load_valid = 1'b0;
        check("send.completed", 64'(done), 64'(nbytes));
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b1;
        bus.load_valid = 1'b0;
        bus.frame      = '0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_idle_outputs("reset");

        // Straight frame with the consumer always ready.
        load_frame(40'h5544332211);
        send(0, NBYTES, 1'b0);
        check("t1.bubble_load_ready", 64'(bus.load_ready), 64'd1);
        check("t1.bubble_out_valid",  64'(bus.out_valid),  64'd0);
        check("t1.bubble_busy",       64'(bus.busy),       64'd0);
        step();
        check("t1.idle_load_ready",   64'(bus.load_ready), 64'd1);

        // Back-pressure: bytes must hold while out_ready is low.
        load_frame(40'h5544332211);
        send(1, NBYTES, 1'b0);
        check("t2.end_busy", 64'(bus.busy), 64'd0);

        // A second load offered during SEND is ignored.
        load_frame(40'h5544332211);
        send(0, NBYTES, 1'b1);
        check("t3.end_busy",       64'(bus.busy),       64'd0);
        check("t3.end_load_ready", 64'(bus.load_ready), 64'd1);
        step();
        check("t3.no_capture_valid", 64'(bus.out_valid), 64'd0);
        check("t3.no_capture_busy",  64'(bus.busy),      64'd0);

        // Flush while 0x33 is presented, then a fresh frame.
        load_frame(40'h5544332211);
        send(0, 2, 1'b0);
        check("t4.at_33", 64'(bus.out_byte), 64'h33);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        sb.delete();
        check("t4.flush_out_valid",  64'(bus.out_valid),  64'd0);
        check("t4.flush_load_ready", 64'(bus.load_ready), 64'd1);
        load_frame(40'h0504030201);
        send(0, NBYTES, 1'b0);

        // Reset while 0x22 is presented; the rest of the frame must never appear.
        load_frame(40'h5544332211);
        send(0, 1, 1'b0);
        check("t5.at_22", 64'(bus.out_byte), 64'h22);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        check_idle_outputs("t5.reset");
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t5.no_more_valid", 64'(bus.out_valid), 64'd0);
            check("t5.no_more_byte",  64'(bus.out_byte),  64'd0);
            step();
        end
        bus.out_ready = 1'b0;

        // Load and flush together in IDLE: flush wins, nothing captured.
        bus.frame      = 40'h1234567890;
        bus.load_valid = 1'b1;
        bus.flush      = 1'b1;
        step();
        bus.load_valid = 1'b0;
        bus.flush      = 1'b0;
        check("t6.busy",       64'(bus.busy),       64'd0);
        check("t6.out_valid",  64'(bus.out_valid),  64'd0);
        check("t6.load_ready", 64'(bus.load_ready), 64'd1);
        step();
        check("t6.busy_later", 64'(bus.busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
